// File: rtl/gpio_bank_pkg.sv
// Shared types and constants for the GPIO bank controller.
// GPIO_IRQ_EN widens each channel's config field to carry an interrupt enable.
package gpio_bank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam int FLD_DIR = 0;
  localparam int FLD_INV = 1;
  localparam int FLD_IE  = 2;

`ifdef GPIO_IRQ_EN
  localparam int CHAIN_BITS_PER_IO = 3;
`else
  localparam int CHAIN_BITS_PER_IO = 2;
`endif

  // Counter width able to hold CHAIN_LEN+1, the saturation value.
  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 2);
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-bit, multi-stage input synchroniser with asynchronous active-low clear.
module gpio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gpio_bank_ctrl.sv
// Bank of NUM_IO pad channels with a serial config chain, shadow/live config and
// synchronised inputs. Define GPIO_IRQ_EN to add per-channel rising-edge interrupts.
module gpio_bank_ctrl
  import gpio_bank_pkg::*;
#(
  parameter int NUM_IO      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              CFG_EN,
  input  logic              CFG_IN,
  output logic              CFG_OUT,
  output logic              CFG_DONE,
  output logic              CFG_ERR,
  input  logic [NUM_IO-1:0] A,
  output logic [NUM_IO-1:0] Y,
  input  logic [NUM_IO-1:0] PAD_IN,
  output logic [NUM_IO-1:0] PAD_OUT,
  output logic [NUM_IO-1:0] PAD_OE,
  input  logic [NUM_IO-1:0] IRQ_CLR,
  output logic [NUM_IO-1:0] IRQ_STATUS,
  output logic              IRQ
);

  localparam int W         = CHAIN_BITS_PER_IO;
  localparam int CHAIN_LEN = W * NUM_IO;
  localparam int CNT_W     = cnt_width(CHAIN_LEN);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

  state_e               state_q;
  logic [CHAIN_LEN-1:0] shadow_q;
  logic [CHAIN_LEN-1:0] live_q, live_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 valid_q, valid_d;
  logic                 err_q;
  logic                 commit;

  logic [NUM_IO-1:0] dir_cur, inv_cur, dir_nxt, inv_nxt;
  logic [NUM_IO-1:0] pad_out_q, pad_oe_q;
  logic [NUM_IO-1:0] sync_w, y_w;

  // A commit happens on the CFG_EN fall only when exactly CHAIN_LEN bits arrived.
  assign commit  = (state_q == LOAD) && !CFG_EN && (cnt_q == CNT_FULL);
  assign live_d  = commit ? shadow_q : live_q;
  assign valid_d = valid_q | commit;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dir_cur = '0;
    inv_cur = '0;
    dir_nxt = '0;
    inv_nxt = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      dir_cur[i] = live_q[W*i + FLD_DIR];
      inv_cur[i] = live_q[W*i + FLD_INV];
      dir_nxt[i] = live_d[W*i + FLD_DIR];
      inv_nxt[i] = live_d[W*i + FLD_INV];
    end
  end

  // NOTE: the shadow chain is a plain register, so it is reset like any other flop;
  // a reset mid-load therefore discards both shadow and live configuration.
  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      live_q   <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (CFG_EN) begin
        shadow_q <= {shadow_q[CHAIN_LEN-2:0], CFG_IN};
      end
      live_q  <= live_d;
      valid_q <= valid_d;
      unique case (state_q)
        IDLE, ACTIVE: begin
          if (CFG_EN) begin
            state_q <= LOAD;
            cnt_q   <= CNT_W'(1);
          end
        end
        LOAD: begin
          if (CFG_EN) begin
            if (cnt_q != CNT_SAT) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (commit) begin
            err_q   <= 1'b0;
            state_q <= ACTIVE;
          end else begin
            err_q   <= 1'b1;
            state_q <= valid_q ? ACTIVE : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output registers look at the next live config so the first post-commit cycle is current.
  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      pad_out_q <= '0;
      pad_oe_q  <= '0;
    end else begin
      pad_oe_q  <= valid_d ? dir_nxt : '0;
      pad_out_q <= valid_d ? ((A ^ inv_nxt) & dir_nxt) : '0;
    end
  end

  gpio_sync #(
    .WIDTH  (NUM_IO),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (CK),
    .rst_n (RST),
    .d_i   (PAD_IN),
    .q_o   (sync_w)
  );

  assign y_w = valid_q ? (sync_w ^ inv_cur) : '0;

`ifdef GPIO_IRQ_EN
  logic [NUM_IO-1:0] ie_cur, ie_nxt;
  logic [NUM_IO-1:0] y_prev_q, rise;
  logic [NUM_IO-1:0] irq_st_q, irq_st_d;
  logic              irq_q;

  always_comb begin
    ie_cur = '0;
    ie_nxt = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      ie_cur[i] = live_q[W*i + FLD_IE];
      ie_nxt[i] = live_d[W*i + FLD_IE];
    end
  end

  // Set dominates clear; a commit drops flags on channels whose IE goes low.
  always_comb begin
    rise     = y_w & ~y_prev_q & ~dir_cur & ie_cur;
    irq_st_d = (irq_st_q & ~IRQ_CLR) | rise;
    if (commit) begin
      irq_st_d = irq_st_d & ie_nxt;
    end
  end

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      y_prev_q <= '0;
      irq_st_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      y_prev_q <= y_w;
      irq_st_q <= irq_st_d;
      irq_q    <= |irq_st_q;
    end
  end

  assign IRQ_STATUS = irq_st_q;
  assign IRQ        = irq_q;
`else
  logic irq_clr_unused;
  assign irq_clr_unused = ^IRQ_CLR;
  assign IRQ_STATUS     = '0;
  assign IRQ            = 1'b0;
`endif

  assign CFG_OUT  = shadow_q[CHAIN_LEN-1];
  assign CFG_DONE = valid_q;
  assign CFG_ERR  = err_q;
  assign Y        = y_w;
  assign PAD_OUT  = pad_out_q;
  assign PAD_OE   = pad_oe_q;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Scoreboard bench for gpio_bank_ctrl: expectations are queued with a due cycle
// when stimulus is applied and compared at the falling edge of that cycle.
module tb_gpio_bank_ctrl;
  import gpio_bank_pkg::*;

  localparam int NUM_IO    = 8;
  localparam int W         = CHAIN_BITS_PER_IO;
  localparam int CHAIN_LEN = W * NUM_IO;

  logic              CK, RST, CFG_EN, CFG_IN;
  logic              CFG_OUT, CFG_DONE, CFG_ERR, IRQ;
  logic [NUM_IO-1:0] A, Y, PAD_IN, PAD_OUT, PAD_OE, IRQ_CLR, IRQ_STATUS;

  gpio_bank_ctrl #(.NUM_IO(NUM_IO), .SYNC_STAGES(2)) dut (
    .CK         (CK),
    .RST        (RST),
    .CFG_EN     (CFG_EN),
    .CFG_IN     (CFG_IN),
    .CFG_OUT    (CFG_OUT),
    .CFG_DONE   (CFG_DONE),
    .CFG_ERR    (CFG_ERR),
    .A          (A),
    .Y          (Y),
    .PAD_IN     (PAD_IN),
    .PAD_OUT    (PAD_OUT),
    .PAD_OE     (PAD_OE),
    .IRQ_CLR    (IRQ_CLR),
    .IRQ_STATUS (IRQ_STATUS),
    .IRQ        (IRQ)
  );

  typedef enum {S_OE, S_OUT, S_Y, S_DONE, S_ERR, S_CFGOUT, S_IRQST, S_IRQ} sig_e;
  typedef struct {
    string      tag;
    sig_e       sig;
    logic [7:0] exp;
    int         due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  initial CK = 1'b0;
  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %02h, expected %02h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] sample(input sig_e s);
    case (s)
      S_OE:     return PAD_OE;
      S_OUT:    return PAD_OUT;
      S_Y:      return Y;
      S_DONE:   return {7'd0, CFG_DONE};
      S_ERR:    return {7'd0, CFG_ERR};
      S_CFGOUT: return {7'd0, CFG_OUT};
      S_IRQST:  return IRQ_STATUS;
      default:  return {7'd0, IRQ};
    endcase
  endfunction

  task automatic expect_sig(input string tag, input sig_e sig, input logic [7:0] exp,
                            input int dly);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    e.due = cyc + dly;
    sb_q.push_back(e);
  endtask

  always @(negedge CK) begin
    int i;
    i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].due == cyc) begin
        check(sb_q[i].tag, sample(sb_q[i].sig), sb_q[i].exp);
        sb_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CK);
      #1;
    end
  endtask

  function automatic logic [63:0] cfg_word(input logic [7:0] dir, input logic [7:0] inv,
                                           input logic [7:0] ie);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      w[W*i + FLD_DIR] = dir[i];
      w[W*i + FLD_INV] = inv[i];
      if (W > 2) w[W*i + FLD_IE] = ie[i];
    end
    return w;
  endfunction

  // Shifts the low n bits of v, MSB first, then lowers CFG_EN without stepping.
  task automatic shift_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      CFG_EN = 1'b1;
      CFG_IN = v[i];
      step(1);
    end
    CFG_EN = 1'b0;
    CFG_IN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] word1, word2, word3;
    logic [7:0]  msb;
    RST = 1'b0; CFG_EN = 1'b0; CFG_IN = 1'b0;
    A = '0; PAD_IN = '1; IRQ_CLR = '0;
    step(2);

    // Reset state, and it holds without a valid load.
    expect_sig("rst_oe",   S_OE,   8'h00, 0);
    expect_sig("rst_y",    S_Y,    8'h00, 0);
    expect_sig("rst_done", S_DONE, 8'h00, 0);
    expect_sig("rst_irq",  S_IRQ,  8'h00, 0);
    expect_sig("rst_err",  S_ERR,  8'h00, 0);
    step(1);
    RST = 1'b1;
    step(5);
    expect_sig("hold_oe",   S_OE,   8'h00, 0);
    expect_sig("hold_y",    S_Y,    8'h00, 0);
    expect_sig("hold_done", S_DONE, 8'h00, 0);
    step(1);

    // Valid load: ch0..3 outputs, ch4..7 inverted inputs.
    word1 = cfg_word(8'h0F, 8'hF0, 8'h00);
    msb   = {7'd0, word1[CHAIN_LEN-1]};
    shift_bits(word1, CHAIN_LEN);
    expect_sig("load_done_pre", S_DONE,   8'h00, 0);
    expect_sig("load_done",     S_DONE,   8'h01, 1);
    expect_sig("load_oe",       S_OE,     8'h0F, 1);
    expect_sig("load_err",      S_ERR,    8'h00, 1);
    expect_sig("load_cfgout",   S_CFGOUT, msb,   1);
    expect_sig("load_y_pad_ff", S_Y,      8'h0F, 1);
    step(1);
    A = 8'hA5; PAD_IN = 8'h00;
    expect_sig("out_a5",     S_OUT, 8'h05, 1);
    expect_sig("y_lat1_old", S_Y,   8'h0F, 1);
    expect_sig("y_pad00",    S_Y,   8'hF0, 2);
    step(1);
    A = 8'h3C; PAD_IN = 8'h5A;
    expect_sig("out_3c",  S_OUT, 8'h0C, 1);
    expect_sig("y_pad5a", S_Y,   8'hAA, 2);
    step(3);

    // Short reload from ACTIVE: error, old config retained.
    shift_bits(64'd0, CHAIN_LEN - 1);
    expect_sig("short_done_mid", S_DONE, 8'h01, 0);
    expect_sig("short_err",      S_ERR,  8'h01, 1);
    expect_sig("short_done",     S_DONE, 8'h01, 1);
    expect_sig("short_oe",       S_OE,   8'h0F, 1);
    step(2);

    // Long reload: error, no commit; then an exact load clears the error.
    word2 = cfg_word(8'hFF, 8'h00, 8'h00);
    shift_bits(word2, CHAIN_LEN + 1);
    expect_sig("long_err", S_ERR, 8'h01, 1);
    expect_sig("long_oe",  S_OE,  8'h0F, 1);
    step(2);
    shift_bits(word2, CHAIN_LEN);
    expect_sig("exact_err", S_ERR, 8'h00, 1);
    expect_sig("exact_oe",  S_OE,  8'hFF, 1);
    expect_sig("exact_out", S_OUT, 8'h3C, 1);
    step(2);

    // Asynchronous reset in the middle of a load.
    for (int i = CHAIN_LEN - 1; i > CHAIN_LEN - 1 - 9; i--) begin
      CFG_EN = 1'b1;
      CFG_IN = word1[i];
      step(1);
    end
    RST = 1'b0; CFG_EN = 1'b0;
    expect_sig("arst_oe",   S_OE,   8'h00, 0);
    expect_sig("arst_out",  S_OUT,  8'h00, 0);
    expect_sig("arst_done", S_DONE, 8'h00, 0);
    expect_sig("arst_y",    S_Y,    8'h00, 0);
    step(1);
    RST = 1'b1;
    step(3);
    expect_sig("lost_done", S_DONE, 8'h00, 0);
    expect_sig("lost_oe",   S_OE,   8'h00, 0);
    step(1);

    // Channel 2 as an interrupt-enabled input.
    A = '0; PAD_IN = '0;
    word3 = cfg_word(8'h00, 8'h00, 8'h04);
    shift_bits(word3, CHAIN_LEN);
    expect_sig("irqcfg_done", S_DONE, 8'h01, 1);
    expect_sig("irqcfg_oe",   S_OE,   8'h00, 1);
    step(4);
    PAD_IN = 8'h04;
    expect_sig("ch2_y", S_Y, 8'h04, 2);
`ifdef GPIO_IRQ_EN
    expect_sig("irqst_early", S_IRQST, 8'h00, 2);
    expect_sig("irqst_set",   S_IRQST, 8'h04, 3);
    expect_sig("irq_lag",     S_IRQ,   8'h00, 3);
    expect_sig("irq_set",     S_IRQ,   8'h01, 4);
`else
    expect_sig("irqst_off", S_IRQST, 8'h00, 3);
    expect_sig("irq_off",   S_IRQ,   8'h00, 4);
`endif
    step(5);
    IRQ_CLR = 8'h04;
`ifdef GPIO_IRQ_EN
    expect_sig("irqst_clr", S_IRQST, 8'h00, 1);
`endif
    expect_sig("irq_clr", S_IRQ, 8'h00, 2);
    step(1);
    IRQ_CLR = '0;
    step(3);
    PAD_IN = 8'h00;
    step(4);
    PAD_IN = 8'h04;
    step(2);
    IRQ_CLR = 8'h04;
`ifdef GPIO_IRQ_EN
    expect_sig("set_wins",      S_IRQST, 8'h04, 1);
    expect_sig("set_wins_hold", S_IRQST, 8'h04, 2);
`else
    expect_sig("irqst_off2", S_IRQST, 8'h00, 1);
`endif
    step(1);
    IRQ_CLR = '0;
    step(3);

    for (int k = 0; k < 20 && sb_q.size() != 0; k++) step(1);
    while (sb_q.size() != 0) begin
      check({sb_q[0].tag, "_not_sampled"}, ~sb_q[0].exp, sb_q[0].exp);
      sb_q.delete(0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
